// File: rtl/freq_meter_mc.sv
// Multi-channel frequency/period meter: measures clk cycles spanned by N
// signal periods on one selected asynchronous input, with timeout and abort.
module freq_meter_mc #(
  parameter int NUM_CH = 8,
  parameter int CH_W   = 3,
  parameter int CNT_W  = 8,
  parameter int TO_W   = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [CH_W-1:0]   i_ch,
  input  logic [1:0]        i_mode,
  input  logic [CNT_W-1:0]  i_cnt,
  input  logic [TO_W-1:0]   i_timeout,
  input  logic [NUM_CH-1:0] i_io,
  output logic [DATA_W-1:0] o_freq,
  output logic [CNT_W-1:0]  o_cnt,
  output logic [1:0]        o_err,
  output logic              o_busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ARM   = 2'd1;
  localparam logic [1:0] S_COUNT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [1:0] E_OK      = 2'b00;
  localparam logic [1:0] E_TIMEOUT = 2'b01;
  localparam logic [1:0] E_ABORT   = 2'b10;
  localparam logic [1:0] E_BADCH   = 2'b11;

  localparam logic [1:0] M_FALL = 2'b01;
  localparam logic [1:0] M_BOTH = 2'b10;

  localparam logic [CH_W:0] CH_LIMIT = (CH_W+1)'(NUM_CH);

  logic [1:0]        state;
  logic [CH_W-1:0]   ch_q;
  logic [1:0]        mode_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [TO_W-1:0]   to_q;
  logic              bad_q;
  logic [DATA_W-1:0] elapsed;
  logic [CNT_W-1:0]  edge_cnt;

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic              prev;
  logic              sel_bit;
  logic              new_bit;
  logic              edge_hit;
  logic              bad_ch;
  logic              timeout;
  logic [DATA_W-1:0] elapsed_inc;
  logic [CNT_W-1:0]  edge_next;
  logic              last_edge;

  logic              fin;
  logic [1:0]        fin_err;
  logic [DATA_W-1:0] fin_freq;
  logic [CNT_W-1:0]  fin_cnt;
  logic              go_count;
  logic              count_edge;

  // Synchronisers run continuously so a newly selected channel is already settled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= i_io;
      sync2 <= sync1;
    end
  end

  always_comb begin
    sel_bit = 1'b0;
    new_bit = 1'b0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (ch_q == CH_W'(k)) sel_bit = sync2[k];
      if (i_ch == CH_W'(k)) new_bit = sync2[k];
    end
  end

  // prev follows the channel about to be observed, so a switch never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev <= 1'b0;
    end else if (start) begin
      prev <= new_bit;
    end else begin
      prev <= sel_bit;
    end
  end

  always_comb begin
    case (mode_q)
      M_FALL:  edge_hit = ~sel_bit & prev;
      M_BOTH:  edge_hit = sel_bit ^ prev;
      default: edge_hit = sel_bit & ~prev;
    endcase
  end

  assign bad_ch      = {1'b0, i_ch} >= CH_LIMIT;
  assign elapsed_inc = (&elapsed) ? elapsed : elapsed + DATA_W'(1);
  assign timeout     = (elapsed[DATA_W-1 -: TO_W] > to_q) || (&elapsed);
  assign edge_next   = edge_cnt + CNT_W'(1);
  assign last_edge   = (edge_next == cnt_q);

  // Completion beats timeout; abort beats both.
  always_comb begin
    fin        = 1'b0;
    fin_err    = E_OK;
    fin_freq   = elapsed;
    fin_cnt    = edge_cnt;
    go_count   = 1'b0;
    count_edge = 1'b0;
    case (state)
      S_ARM: begin
        if (bad_q) begin
          fin      = 1'b1;
          fin_err  = E_BADCH;
          fin_freq = '0;
          fin_cnt  = '0;
        end else if (abort) begin
          fin     = 1'b1;
          fin_err = E_ABORT;
        end else if (edge_hit) begin
          if (cnt_q == '0) begin
            fin      = 1'b1;
            fin_freq = '0;
            fin_cnt  = '0;
          end else begin
            go_count = 1'b1;
          end
        end else if (timeout) begin
          fin     = 1'b1;
          fin_err = E_TIMEOUT;
        end
      end
      S_COUNT: begin
        if (abort) begin
          fin     = 1'b1;
          fin_err = E_ABORT;
        end else if (edge_hit && last_edge) begin
          fin      = 1'b1;
          fin_freq = elapsed_inc;
          fin_cnt  = cnt_q;
        end else if (timeout) begin
          fin     = 1'b1;
          fin_err = E_TIMEOUT;
        end else if (edge_hit) begin
          count_edge = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ch_q     <= '0;
      mode_q   <= '0;
      cnt_q    <= '0;
      to_q     <= '0;
      bad_q    <= 1'b0;
      elapsed  <= '0;
      edge_cnt <= '0;
      o_freq   <= '0;
      o_cnt    <= '0;
      o_err    <= E_OK;
      o_busy   <= 1'b0;
      done     <= 1'b0;
    end else if (start) begin
      state    <= S_ARM;
      ch_q     <= i_ch;
      mode_q   <= i_mode;
      cnt_q    <= i_cnt;
      to_q     <= i_timeout;
      bad_q    <= bad_ch;
      elapsed  <= '0;
      edge_cnt <= '0;
      o_freq   <= '0;
      o_cnt    <= '0;
      o_err    <= E_OK;
      o_busy   <= 1'b1;
      done     <= 1'b0;
    end else if (fin) begin
      state  <= S_DONE;
      o_freq <= fin_freq;
      o_cnt  <= fin_cnt;
      o_err  <= fin_err;
      o_busy <= 1'b0;
      done   <= 1'b1;
    end else if (go_count) begin
      state   <= S_COUNT;
      elapsed <= '0;
    end else if (state == S_ARM || state == S_COUNT) begin
      elapsed <= elapsed_inc;
      if (count_edge) edge_cnt <= edge_next;
    end
  end

endmodule

// File: tb/tb_freq_meter_mc.sv
// Bench for freq_meter_mc: synchronous waveforms on every channel, expected
// results derived from qualified edge times, start/abort cycles and timeout rules.
module tb_freq_meter_mc;
  localparam int NUM_CH = 6;
  localparam int CH_W   = 3;
  localparam int CNT_W  = 8;
  localparam int TO_W   = 8;
  localparam int DATA_W = 16;
  localparam int BIG    = 32'h3fff_ffff;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic [CH_W-1:0]   i_ch = '0;
  logic [1:0]        i_mode = '0;
  logic [CNT_W-1:0]  i_cnt = '0;
  logic [TO_W-1:0]   i_timeout = '0;
  logic [NUM_CH-1:0] i_io = '0;
  logic [DATA_W-1:0] o_freq;
  logic [CNT_W-1:0]  o_cnt;
  logic [1:0]        o_err;
  logic              o_busy;
  logic              done;

  always #5 clk = ~clk;

  freq_meter_mc #(
    .NUM_CH(NUM_CH), .CH_W(CH_W), .CNT_W(CNT_W), .TO_W(TO_W), .DATA_W(DATA_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .i_ch(i_ch), .i_mode(i_mode), .i_cnt(i_cnt), .i_timeout(i_timeout),
    .i_io(i_io), .o_freq(o_freq), .o_cnt(o_cnt), .o_err(o_err),
    .o_busy(o_busy), .done(done)
  );

  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  int w_on[NUM_CH];
  int w_per[NUM_CH];
  int w_hi[NUM_CH];
  int w_idle[NUM_CH];
  int w_off[NUM_CH];
  int w_t0[NUM_CH];
  int sel_ch = NUM_CH;
  int sel_mode = 0;
  int edge_q[$];
  int ab_edges = -1;
  int ab_drive = -1;
  int ab_at = -1;
  int meas_s, meas_ch, meas_cnt, meas_to;
  int done_cyc;
  bit got_done;
  int exp_freq, exp_cnt, exp_err, exp_done;

  task automatic tick();
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_wave(input int k, input int on, input int per, input int hi,
                          input int idle, input int off);
    w_on[k] = on; w_per[k] = per; w_hi[k] = hi; w_idle[k] = idle; w_off[k] = off;
  endtask

  task automatic clear_waves();
    for (int k = 0; k < NUM_CH; k++) set_wave(k, 0, 10, 5, 0, 0);
  endtask

  // Drive this cycle's levels; a qualifying change on the watched channel is
  // recognised by the meter three clocks later.
  task automatic drive_io();
    logic [NUM_CH-1:0] nv;
    logic o, n;
    for (int k = 0; k < NUM_CH; k++) begin
      if (w_on[k] != 0 && cyc >= w_t0[k]) nv[k] = (((cyc - w_t0[k]) % w_per[k]) < w_hi[k]);
      else nv[k] = (w_idle[k] != 0);
    end
    if (sel_ch < NUM_CH) begin
      o = i_io[sel_ch];
      n = nv[sel_ch];
      if (o != n) begin
        if (sel_mode == 2 || (sel_mode == 1 && !n) || (sel_mode != 1 && sel_mode != 2 && n))
          edge_q.push_back(cyc + 3);
      end
    end
    i_io = nv;
  endtask

  task automatic park(input int n);
    for (int k = 0; k < NUM_CH; k++) w_on[k] = 0;
    for (int j = 0; j < n; j++) begin
      drive_io();
      tick();
    end
  endtask

  task automatic begin_meas(input int ch, input int mode, input int cnt, input int to, input int abe);
    i_ch = ch[CH_W-1:0];
    i_mode = mode[1:0];
    i_cnt = cnt[CNT_W-1:0];
    i_timeout = to[TO_W-1:0];
    start = 1'b1;
    meas_s = cyc + 1;
    meas_ch = ch; meas_cnt = cnt; meas_to = to;
    for (int k = 0; k < NUM_CH; k++) w_t0[k] = meas_s + w_off[k];
    edge_q.delete();
    sel_ch = ch; sel_mode = mode;
    ab_edges = abe; ab_drive = -1; ab_at = -1;
    drive_io();
    tick();
    start = 1'b0;
  endtask

  task automatic wait_meas(input int budget);
    got_done = 1'b0;
    done_cyc = -1;
    for (int n = 0; n < budget; n++) begin
      if (done === 1'b1) begin
        got_done = 1'b1;
        done_cyc = cyc;
        break;
      end
      abort = 1'b0;
      if (ab_edges >= 0 && ab_drive < 0 && edge_q.size() > ab_edges) ab_drive = edge_q[ab_edges] + 2;
      if (cyc == ab_drive) begin
        abort = 1'b1;
        ab_at = cyc + 1;
      end
      drive_io();
      tick();
    end
    abort = 1'b0;
  endtask

  function automatic void set_exp(input int f, input int c, input int e, input int d);
    exp_freq = f; exp_cnt = c; exp_err = e; exp_done = d;
  endfunction

  // Event-ordered reference: start at meas_s, qualifying edges at edge_q, abort at
  // ab_at; elapsed reads m-1 at the m-th clock after it was cleared.
  function automatic void model();
    int thr, first, abt, tarm, f, n, e, tcnt;
    thr = (meas_to + 1) << (DATA_W - TO_W);
    if (thr > (1 << DATA_W) - 1) thr = (1 << DATA_W) - 1;
    abt = (ab_at >= 0) ? ab_at : BIG;
    if (meas_ch >= NUM_CH) begin set_exp(0, 0, 3, meas_s + 1); return; end
    first = (edge_q.size() > 0) ? edge_q[0] : BIG;
    tarm = meas_s + thr + 1;
    if (abt <= first && abt <= tarm) begin set_exp(abt - meas_s - 1, 0, 2, abt); return; end
    if (first > tarm) begin set_exp(thr, 0, 1, tarm); return; end
    if (meas_cnt == 0) begin set_exp(0, 0, 0, first); return; end
    f = first; n = 0; tcnt = f + thr + 1;
    for (int i = 1; i <= edge_q.size(); i++) begin
      e = (i < edge_q.size()) ? edge_q[i] : BIG;
      if (abt <= e && abt <= tcnt) begin set_exp(abt - f - 1, n, 2, abt); return; end
      if (e <= tcnt && n + 1 == meas_cnt) begin set_exp(e - f, meas_cnt, 0, e); return; end
      if (e < tcnt) n++;
      else begin set_exp(thr, n, 1, tcnt); return; end
    end
  endfunction

  task automatic check_meas(input string tag);
    check({tag, "_seen"}, got_done, 1);
    model();
    check({tag, "_when"}, done_cyc, exp_done);
    check({tag, "_freq"}, o_freq, exp_freq);
    check({tag, "_cnt"}, o_cnt, exp_cnt);
    check({tag, "_err"}, o_err, exp_err);
    check({tag, "_busy"}, o_busy, 0);
  endtask

  initial begin
    int on_r[NUM_CH];
    int per, ch, mode, cnt, to, abe;
    clear_waves();
    repeat (3) tick();
    check("rst_freq", o_freq, 0);
    check("rst_cnt", o_cnt, 0);
    check("rst_err", o_err, 0);
    check("rst_busy", o_busy, 0);
    check("rst_done", done, 0);
    rst_n = 1'b1;
    park(4);

    // ch3 rising, period 10, four periods; ch5 toggles as a distraction
    clear_waves();
    set_wave(5, 0, 7, 3, 1, 0);
    park(4);
    set_wave(3, 1, 10, 5, 0, 4);
    set_wave(5, 1, 7, 3, 1, 0);
    begin_meas(3, 0, 4, 8, -1);
    check("run_busy", o_busy, 1);
    check("run_done_low", done, 0);
    wait_meas(4000);
    check_meas("ch3_rise");
    check("ch3_rise_const", o_freq, 40);
    park(6);
    check("hold_freq", o_freq, 40);
    check("hold_done", done, 1);

    // ch0 both edges then falling
    clear_waves();
    park(4);
    set_wave(0, 1, 10, 5, 0, 3);
    begin_meas(0, 2, 4, 8, -1);
    wait_meas(4000);
    check_meas("ch0_both");
    check("ch0_both_const", o_freq, 20);
    park(5);
    set_wave(0, 1, 10, 5, 0, 3);
    begin_meas(0, 1, 4, 8, -1);
    wait_meas(4000);
    check_meas("ch0_fall");
    check("ch0_fall_const", o_freq, 40);

    // static input, timeout threshold 2
    clear_waves();
    set_wave(2, 0, 10, 5, 1, 0);
    park(5);
    set_wave(1, 1, 9, 4, 0, 0);
    begin_meas(2, 0, 4, 2, -1);
    wait_meas(4000);
    check_meas("timeout");
    check("timeout_freq_const", o_freq, 768);
    check("timeout_err_const", o_err, 1);
    check("timeout_lat_const", done_cyc - meas_s, 769);

    // zero periods requested
    clear_waves();
    park(5);
    set_wave(4, 1, 12, 6, 0, 5);
    begin_meas(4, 0, 0, 5, -1);
    wait_meas(4000);
    check_meas("cnt_zero");
    check("cnt_zero_lat", done_cyc, meas_s + 5 + 3);

    // out-of-range channels
    park(5);
    begin_meas(NUM_CH, 0, 4, 8, -1);
    wait_meas(100);
    check_meas("bad_ch6");
    check("bad_ch6_lat", done_cyc - meas_s, 1);
    park(3);
    begin_meas(7, 2, 1, 1, -1);
    wait_meas(100);
    check_meas("bad_ch7");

    // abort after two counted intervals
    clear_waves();
    park(5);
    set_wave(1, 1, 10, 5, 0, 2);
    begin_meas(1, 0, 6, 8, 2);
    wait_meas(4000);
    check_meas("abort");
    check("abort_cnt_const", o_cnt, 2);
    check("abort_err_const", o_err, 2);

    // restart on a new channel that idles high while the old one sits low
    clear_waves();
    set_wave(5, 0, 10, 5, 1, 0);
    park(5);
    set_wave(1, 1, 8, 4, 0, 2);
    begin_meas(1, 0, 6, 8, -1);
    for (int j = 0; j < 30; j++) begin drive_io(); tick(); end
    check("restart_busy_a", o_busy, 1);
    w_on[1] = 0;
    for (int j = 0; j < 3; j++) begin drive_io(); tick(); end
    set_wave(5, 1, 10, 5, 1, 6);
    begin_meas(5, 0, 3, 8, -1);
    wait_meas(4000);
    check_meas("restart");
    check("restart_const", o_freq, 30);

    // reset in the middle of a count
    clear_waves();
    park(5);
    set_wave(2, 1, 10, 5, 0, 2);
    begin_meas(2, 0, 8, 8, -1);
    for (int j = 0; j < 40; j++) begin drive_io(); tick(); end
    check("pre_rst_busy", o_busy, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", o_busy, 0);
    check("mid_rst_done", done, 0);
    check("mid_rst_freq", o_freq, 0);
    check("mid_rst_cnt", o_cnt, 0);
    check("mid_rst_err", o_err, 0);
    repeat (2) tick();
    rst_n = 1'b1;
    park(5);
    set_wave(2, 1, 10, 5, 0, 2);
    begin_meas(2, 0, 3, 8, -1);
    wait_meas(4000);
    check_meas("post_rst");
    check("post_rst_const", o_freq, 30);

    // randomized measurements with activity on every channel
    for (int it = 0; it < 12; it++) begin
      for (int k = 0; k < NUM_CH; k++) begin
        per = ($urandom_range(0, 3) == 0) ? int'($urandom_range(80, 150)) : int'($urandom_range(3, 60));
        set_wave(k, 0, per, int'($urandom_range(1, per - 1)), int'($urandom_range(0, 1)),
                 int'($urandom_range(0, 20)));
        on_r[k] = ($urandom_range(0, 3) != 0) ? 1 : 0;
      end
      park(5);
      for (int k = 0; k < NUM_CH; k++) w_on[k] = on_r[k];
      ch   = ($urandom_range(0, 9) == 0) ? int'($urandom_range(NUM_CH, 7)) : int'($urandom_range(0, NUM_CH - 1));
      mode = $urandom_range(0, 3);
      cnt  = $urandom_range(0, 6);
      to   = $urandom_range(0, 3);
      abe  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 2)) : -1;
      begin_meas(ch, mode, cnt, to, abe);
      wait_meas(4000);
      check_meas($sformatf("rnd%0d", it));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
